display_mode_scheduler: RTL
===========================

# display_mode_scheduler

Time-multiplexes the single 4-digit seven-segment display among the four fitness metrics: total steps, distance, steps-over-32 count and high-activity seconds. Each enabled metric is shown for a programmable number of seconds, then the block advances to the next one. Disabled metrics are skipped, and the rotation can be frozen. The block sits between the step-count/metric datapath and the seven-segment driver and is the only source of the driver's 14-bit value bus.

## Interface
- DWELL_TICKS, 2, seconds each metric stays on the display (≥1)
- CLK  in  1  system clock; all logic is on the rising edge
- RESET  in  1  synchronous, active-high reset
- SEC_TICK  in  1  one-cycle strobe, once per second
- HOLD  in  1  level; freezes rotation while high
- MODE_MASK  in  4  bit i=1 enables metric i (0 total steps, 1 distance, 2 steps over 32, 3 high-activity seconds)
- TOTAL_STEPS  in  14  metric 0
- DISTANCE  in  14  metric 1, in tenths of a mile
- STEPS_OVER_32  in  14  metric 2
- HIGH_ACT_SEC  in  14  metric 3
- DISP_VALUE  out  14  value to the seven-segment driver
- DISP_MODE  out  2  index of the metric currently shown
- DISP_DP  out  1  decimal point at tenths position; 1 only in mode 1
- DISP_SAT  out  1  shown value was clamped
- DISP_BLANK  out  1  display off (no metric enabled)
- MODE_CHANGE  out  1  one-cycle pulse when DISP_MODE takes a new value

## Operation
- State registers: fsm ∈ {BLANK, SHOW}, mode[1:0], dwell counter of width clog2(DWELL_TICKS) (minimum 1 bit).
- next(m) = first enabled index after m, searching cyclically m+1, m+2, m+3, m. If only m is enabled, next(m)=m.
- BLANK:
  - If MODE_MASK≠0: go to SHOW, mode = lowest enabled index, dwell=0.
- SHOW, in priority order:
  - MODE_MASK==0 → BLANK. mode is held.
  - MODE_MASK[mode]==0 → mode=next(mode), dwell=0. HOLD does not block this step.
  - SEC_TICK & ~HOLD & dwell==DWELL_TICKS-1 → mode=next(mode), dwell=0.
  - SEC_TICK & ~HOLD, otherwise → dwell+1.
  - Otherwise hold all state.
- HOLD together with SEC_TICK: HOLD wins, tick is dropped.
- Output stage is registered every cycle from the current state:
  - DISP_MODE = mode.
  - DISP_VALUE = selected metric (0 in BLANK).
  - DISP_DP = (SHOW & mode==1).
  - DISP_BLANK = (fsm==BLANK).
  - MODE_CHANGE = 1 when the registered DISP_MODE differs from its previous value while in SHOW, or on the BLANK→SHOW transition.
- A single-enabled-mode rotation keeps DISP_MODE unchanged and does not pulse MODE_CHANGE.

## Timing
- Reset values: fsm=BLANK, mode=0, dwell=0; DISP_VALUE=0, DISP_MODE=0, DISP_DP=0, DISP_SAT=0, DISP_BLANK=1, MODE_CHANGE=0.
- RESET takes priority over every other input in any state and at any dwell count.
- Outputs lag state by 1 cycle. A metric input change appears on DISP_VALUE 1 cycle later.
- First cycle after RESET falls with MODE_MASK≠0:
  - Cycle n: state enters SHOW.
  - Cycle n+1: outputs show the metric, MODE_CHANGE=1.
- Dwell expiry: the tick sampled at cycle n updates mode at n+1 and outputs at n+2.
- Mask-disable of the current mode: new mode is in state 1 cycle later and on the outputs 2 cycles later.
- Metric inputs are treated as synchronous to CLK. The block does no CDC.

## Configuration
- DISP_SATURATE_EN defined:
  - Selected value >9999 → DISP_VALUE=9999, DISP_SAT=1.
  - Otherwise DISP_SAT=0 and the value passes unchanged.
- Not defined:
  - DISP_VALUE = raw 14-bit value (up to 16383).
  - DISP_SAT is constant 0.

## Test plan
- Reset release, MODE_MASK=4'b1111, DWELL_TICKS=2, SEC_TICK every 10 cycles → DISP_MODE sequence 0,1,2,3,0. Each mode lasts exactly 2 ticks. MODE_CHANGE pulses once per change. DISP_DP=1 only in mode 1.
- MODE_MASK=4'b0101 → rotation 0,2,0,2. Then clear bit 2 while in mode 2 → DISP_MODE=0 two cycles later and dwell restarts. Then MODE_MASK=4'b0001 → DISP_MODE stays 0 with no further MODE_CHANGE.
- MODE_MASK=0 → DISP_BLANK=1, DISP_VALUE=0. Then set MODE_MASK=4'b1000 → DISP_MODE=3, DISP_BLANK=0, one MODE_CHANGE pulse.
- HOLD=1 across 5 ticks, including a tick in the same cycle HOLD rises → mode unchanged. After HOLD falls, 2 more ticks are needed to advance.
- TOTAL_STEPS=12000 in mode 0 → DISP_VALUE=9999 with DISP_SAT=1 under DISP_SATURATE_EN; DISP_VALUE=12000 with DISP_SAT=0 without it. TOTAL_STEPS=42 → 42, DISP_SAT=0.
- RESET asserted mid-dwell in mode 2 → next cycle all outputs at reset values. After release, display restarts at the lowest enabled mode with dwell=0.

Source files
------------

// File: rtl/display_mode_scheduler_if.sv
// Bundle between the metric datapath, the display mode scheduler and the seven-segment driver.
// The master drives the metrics and rotation controls; the slave (scheduler) drives the display bus.
interface display_mode_scheduler_if;
  logic        sec_tick;
  logic        hold;
  logic [3:0]  mode_mask;
  logic [13:0] total_steps;
  logic [13:0] distance;
  logic [13:0] steps_over_32;
  logic [13:0] high_act_sec;
  logic [13:0] disp_value;
  logic [1:0]  disp_mode;
  logic        disp_dp;
  logic        disp_sat;
  logic        disp_blank;
  logic        mode_change;

  modport master (
    output sec_tick, hold, mode_mask, total_steps, distance, steps_over_32, high_act_sec,
    input  disp_value, disp_mode, disp_dp, disp_sat, disp_blank, mode_change
  );

  modport slave (
    input  sec_tick, hold, mode_mask, total_steps, distance, steps_over_32, high_act_sec,
    output disp_value, disp_mode, disp_dp, disp_sat, disp_blank, mode_change
  );
endinterface

// File: rtl/display_mode_scheduler.sv
// Rotates the four fitness metrics onto the single seven-segment display, DWELL_TICKS seconds each.
// Define DISP_SATURATE_EN to clamp displayed values above 9999 and flag them on disp_sat.
module display_mode_scheduler #(
  parameter int DWELL_TICKS = 2
) (
  input logic                     clk,
  input logic                     reset,
  display_mode_scheduler_if.slave bus
);

  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t        fsm_r;
  logic [1:0]    mode_r;
  logic [DW-1:0] dwell_r;

  // First enabled index after m, searched cyclically; falls back to m itself.
  function automatic logic [1:0] next_mode(input logic [1:0] m, input logic [3:0] mask);
    logic [1:0] cand;
    next_mode = m;
    for (int i = 3; i >= 1; i--) begin
      cand = m + 2'(i);
      if (mask[cand]) begin
        next_mode = cand;
      end else begin
        next_mode = next_mode;
      end
    end
  endfunction

  function automatic logic [1:0] lowest_mode(input logic [3:0] mask);
    lowest_mode = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_mode = 2'(i);
      end else begin
        lowest_mode = lowest_mode;
      end
    end
  endfunction

  function automatic logic [13:0] select_metric(input logic [1:0] m, input logic [13:0] v0,
                                                input logic [13:0] v1, input logic [13:0] v2,
                                                input logic [13:0] v3);
    case (m)
      2'd0:    select_metric = v0;
      2'd1:    select_metric = v1;
      2'd2:    select_metric = v2;
      2'd3:    select_metric = v3;
      default: select_metric = 14'd0;
    endcase
  endfunction

  logic [13:0] raw_value;
  logic [13:0] shown_value;
  logic        shown_sat;

  // Metric selection and optional clamp, feeding the output registers.
  always_comb begin
    raw_value   = 14'd0;
    shown_value = 14'd0;
    shown_sat   = 1'b0;
    if (fsm_r == SHOW) begin
      raw_value = select_metric(mode_r, bus.total_steps, bus.distance,
                                bus.steps_over_32, bus.high_act_sec);
    end else begin
      raw_value = 14'd0;
    end
`ifdef DISP_SATURATE_EN
    if (raw_value > 14'd9999) begin
      shown_value = 14'd9999;
      shown_sat   = 1'b1;
    end else begin
      shown_value = raw_value;
      shown_sat   = 1'b0;
    end
`else
    shown_value = raw_value;
    shown_sat   = 1'b0;
`endif
  end

  // Rotation state machine plus the registered display outputs (one cycle behind the state).
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r           <= BLANK;
      mode_r          <= 2'd0;
      dwell_r         <= '0;
      bus.disp_value  <= 14'd0;
      bus.disp_mode   <= 2'd0;
      bus.disp_dp     <= 1'b0;
      bus.disp_sat    <= 1'b0;
      bus.disp_blank  <= 1'b1;
      bus.mode_change <= 1'b0;
    end else begin
      case (fsm_r)
        BLANK: begin
          if (bus.mode_mask != 4'b0000) begin
            fsm_r   <= SHOW;
            mode_r  <= lowest_mode(bus.mode_mask);
            dwell_r <= '0;
          end else begin
            fsm_r <= BLANK;
          end
        end
        SHOW: begin
          // A disabled current mode is left immediately, even while held.
          if (bus.mode_mask == 4'b0000) begin
            fsm_r <= BLANK;
          end else if (!bus.mode_mask[mode_r]) begin
            mode_r  <= next_mode(mode_r, bus.mode_mask);
            dwell_r <= '0;
          end else if (bus.sec_tick && !bus.hold && (dwell_r == DWELL_LAST)) begin
            mode_r  <= next_mode(mode_r, bus.mode_mask);
            dwell_r <= '0;
          end else if (bus.sec_tick && !bus.hold) begin
            dwell_r <= dwell_r + DW'(1);
          end else begin
            dwell_r <= dwell_r;
          end
        end
        default: begin
          fsm_r   <= BLANK;
          mode_r  <= 2'd0;
          dwell_r <= '0;
        end
      endcase

      bus.disp_mode   <= mode_r;
      bus.disp_value  <= shown_value;
      bus.disp_sat    <= shown_sat;
      bus.disp_dp     <= (fsm_r == SHOW) && (mode_r == 2'd1);
      bus.disp_blank  <= (fsm_r == BLANK);
      // Previous disp_blank marks the BLANK->SHOW edge so a return to the same mode still pulses.
      bus.mode_change <= (fsm_r == SHOW) && (bus.disp_blank || (bus.disp_mode != mode_r));
    end
  end

endmodule
